tile_blitter: RTL and testbench

TILE_BLITTER -- requirements
Module: tile_blitter

---
 rtl/map_pkg.sv | 19 +
 rtl/tile_fifo.sv | 38 +++
 rtl/tile_blitter.sv | 97 +++++++++
 tb/tb_tile_blitter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/map_pkg.sv
// map_pkg: shared map geometry, shape encodings and tile record for the tile blitter.
package map_pkg;
  localparam int GRID_DIM = 21;
  localparam int TILE_PX_DEF = 5;
  localparam int X_ORIGIN_DEF = 27;
  localparam int Y_ORIGIN_DEF = 7;
  localparam int FIFO_DEPTH = 4;
  localparam logic [1:0] SHAPE_FULL = 2'd0;
  localparam logic [1:0] SHAPE_SMALL = 2'd1;
  localparam logic [1:0] SHAPE_BIG = 2'd2;
  localparam logic [2:0] COLOR_BLACK = 3'b000;
  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
    logic [2:0] color;
    logic [1:0] shape;
  } tile_t;
  typedef enum logic {IDLE, DRAW} state_e;
endpackage

// File: rtl/tile_fifo.sv
// tile_fifo: small FIFO of tile records with occupancy count and full/empty flags.
module tile_fifo
  import map_pkg::*;
(
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            push_i,
  input  logic                            pop_i,
  input  tile_t                           wdata_i,
  output tile_t                           rdata_o,
  output logic [$clog2(FIFO_DEPTH):0]     count_o,
  output logic                            full_o,
  output logic                            empty_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  tile_t mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q;
  logic do_push, do_pop;
  assign full_o = count_q == (AW+1)'(FIFO_DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop = pop_i & ~empty_o;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk_i) if (do_push) mem_q[wr_q] <= wdata_i;
endmodule

// File: rtl/tile_blitter.sv
// tile_blitter: queues tile draw requests and rasterises each tile as TILE_PX*TILE_PX pixel writes.
module tile_blitter
  import map_pkg::*;
#(
  parameter int TILE_PX = TILE_PX_DEF,
  parameter int X_ORIGIN = X_ORIGIN_DEF,
  parameter int Y_ORIGIN = Y_ORIGIN_DEF
) (
  input  logic       clock_50,
  input  logic       resetn,
  input  logic       tile_valid,
  output logic       tile_ready,
  input  logic [4:0] tile_x,
  input  logic [4:0] tile_y,
  input  logic [2:0] tile_color,
  input  logic [1:0] tile_shape,
  output logic       vga_plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_color,
  output logic       busy,
  output logic [7:0] drop_count
);
  localparam int PW = $clog2(TILE_PX + 1);
  localparam logic [PW-1:0] LAST = PW'(TILE_PX - 1);
  state_e state_q, state_d;
  tile_t tile_q, tile_d, head;
  logic [PW-1:0] px_q, px_d, py_q, py_d;
  logic [7:0] drop_q, pix_x;
  logic [6:0] pix_y;
  logic [2:0] pix_color;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic full, empty, push, pop, accept, in_range, drawing, last, in_small, in_big;
  assign in_range = tile_x < 5'(GRID_DIM) && tile_y < 5'(GRID_DIM);
  assign tile_ready = resetn & ~full;
  assign accept = tile_valid & tile_ready;
  assign push = accept & in_range;
  assign drawing = state_q == DRAW;
  assign busy = ~empty | drawing;
  assign drop_count = drop_q;
  tile_fifo u_fifo (
    .clk_i(clock_50), .rst_ni(resetn), .push_i(push), .pop_i(pop),
    .wdata_i({tile_x, tile_y, tile_color, tile_shape}), .rdata_o(head),
    .count_o(fifo_count), .full_o(full), .empty_o(empty)
  );
  always_comb begin
    state_d = state_q;
    tile_d = tile_q;
    px_d = px_q;
    py_d = py_q;
    pop = 1'b0;
    last = px_q == LAST && py_q == LAST;
    if (!drawing || last) begin
      pop = ~empty;
      tile_d = empty ? tile_q : head;
      px_d = '0;
      py_d = '0;
      state_d = empty ? IDLE : DRAW;
    end else begin
      px_d = px_q == LAST ? '0 : px_q + 1'b1;
      py_d = px_q == LAST ? py_q + 1'b1 : py_q;
    end
  end
  // Orb masks assume the 5-pixel tile the map art is drawn for.
  always_comb begin
    pix_x = 8'(X_ORIGIN + int'(tile_q.x) * TILE_PX + int'(px_q));
    pix_y = 7'(Y_ORIGIN + int'(tile_q.y) * TILE_PX + int'(py_q));
    in_small = px_q == PW'(2) && py_q == PW'(2);
    in_big = px_q >= PW'(1) && px_q <= PW'(3) && py_q >= PW'(1) && py_q <= PW'(3);
    pix_color = tile_q.shape == SHAPE_SMALL ? (in_small ? tile_q.color : COLOR_BLACK) :
                tile_q.shape == SHAPE_BIG   ? (in_big ? tile_q.color : COLOR_BLACK) :
                tile_q.color;
  end
  always_ff @(posedge clock_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      tile_q <= '0;
      px_q <= '0;
      py_q <= '0;
      drop_q <= '0;
      vga_plot <= 1'b0;
      vga_x <= '0;
      vga_y <= '0;
      vga_color <= '0;
    end else begin
      state_q <= state_d;
      tile_q <= tile_d;
      px_q <= px_d;
      py_q <= py_d;
      drop_q <= (accept && !in_range && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
      vga_plot <= drawing;
      vga_x <= drawing ? pix_x : vga_x;
      vga_y <= drawing ? pix_y : vga_y;
      vga_color <= drawing ? pix_color : vga_color;
    end
  end
endmodule

// File: tb/tb_tile_blitter.sv
// tb_tile_blitter: directed checks of tile queueing, rasterisation, drops and reset.
module tb_tile_blitter;
  logic clock_50 = 1'b0, resetn = 1'b0, tile_valid = 1'b0, tile_ready;
  logic [4:0] tile_x = '0, tile_y = '0;
  logic [2:0] tile_color = '0;
  logic [1:0] tile_shape = '0;
  logic vga_plot, busy;
  logic [7:0] vga_x, drop_count;
  logic [6:0] vga_y;
  logic [2:0] vga_color;
  int nvec = 0, nerr = 0, cyc = 0, hs_cyc = 0;
  logic [7:0] qx[$];
  logic [6:0] qy[$];
  logic [2:0] qc[$];
  int qt[$];

  tile_blitter dut (
    .clock_50(clock_50), .resetn(resetn), .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_x(tile_x), .tile_y(tile_y), .tile_color(tile_color), .tile_shape(tile_shape),
    .vga_plot(vga_plot), .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color),
    .busy(busy), .drop_count(drop_count)
  );

  always #10 clock_50 = ~clock_50;
  always @(posedge clock_50) cyc <= cyc + 1;
  always @(negedge clock_50) if (vga_plot) begin
    qx.push_back(vga_x);
    qy.push_back(vga_y);
    qc.push_back(vga_color);
    qt.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    qx.delete(); qy.delete(); qc.delete(); qt.delete();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!tile_ready && n < 300) begin @(negedge clock_50); n++; end
    if (n >= 300) chk("ready_timeout", 0, 1);
  endtask

  task automatic send(input logic [4:0] x, input logic [4:0] y, input logic [2:0] c, input logic [1:0] s);
    tile_valid = 1'b1; tile_x = x; tile_y = y; tile_color = c; tile_shape = s;
    wait_ready();
    hs_cyc = cyc;
    @(negedge clock_50);
    tile_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || vga_plot) && n < 1000) begin @(negedge clock_50); n++; end
    if (n >= 1000) chk("idle_timeout", 0, 1);
    repeat (3) @(negedge clock_50);
  endtask

  function automatic logic [2:0] exp_col(int s, int c, int px, int py);
    if (s == 1) return (px == 2 && py == 2) ? 3'(c) : 3'b000;
    if (s == 2) return (px >= 1 && px <= 3 && py >= 1 && py <= 3) ? 3'(c) : 3'b000;
    return 3'(c);
  endfunction

  task automatic check_tile(input string tag, input int base, input int tx, input int ty, input int c, input int s);
    if (qx.size() < base + 25) begin
      chk({tag, "_len"}, qx.size(), base + 25);
      return;
    end
    for (int i = 0; i < 25; i++)
      chk(tag, {qx[base+i], qy[base+i], qc[base+i]},
          {8'(27 + tx*5 + i%5), 7'(7 + ty*5 + i/5), exp_col(s, c, i%5, i/5)});
  endtask

  initial begin
    int colored, hs, hs_at_full, xmin, xmax, ymin, ymax;
    logic saw_full;
    repeat (3) @(negedge clock_50);
    chk("rst_plot", vga_plot, 0);
    chk("rst_x", vga_x, 0);
    chk("rst_y", vga_y, 0);
    chk("rst_color", vga_color, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", tile_ready, 0);
    resetn = 1'b1;
    @(negedge clock_50);
    chk("rel_ready", tile_ready, 1);

    clear_q();
    send(0, 0, 3'b001, 0);
    wait_idle();
    chk("t1_count", qx.size(), 25);
    if (qt.size() > 0) begin
      chk("t1_latency", qt[0] - hs_cyc, 3);
      chk("t1_contig", qt[qt.size()-1] - qt[0], 24);
      chk("t1_first_xy", {qx[0], qy[0]}, {8'd27, 7'd7});
      chk("t1_last_xy", {qx[qx.size()-1], qy[qy.size()-1]}, {8'd31, 7'd11});
    end
    check_tile("t1_pix", 0, 0, 0, 1, 0);

    clear_q();
    send(20, 20, 3'b111, 1);
    wait_idle();
    chk("t2_count", qx.size(), 25);
    colored = 0;
    foreach (qc[i]) if (qc[i] != 0) begin
      colored++;
      chk("t2_orb_xy", {qx[i], qy[i], qc[i]}, {8'd129, 7'd109, 3'b111});
    end
    chk("t2_colored", colored, 1);
    if (qx.size() == 25) chk("t2_corner", {qx[24], qy[24]}, {8'd131, 7'd111});
    check_tile("t2_pix", 0, 20, 20, 7, 1);

    clear_q();
    hs = 0; hs_at_full = -1; saw_full = 1'b0;
    tile_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tile_x = 5'(i * 3); tile_y = 5'(i + 1); tile_color = 3'(i + 1); tile_shape = 2'(i % 4);
      if (!tile_ready && !saw_full) begin saw_full = 1'b1; hs_at_full = hs; end
      wait_ready();
      hs++;
      @(negedge clock_50);
    end
    tile_valid = 1'b0;
    chk("t3_saw_full", saw_full, 1);
    chk("t3_hs_at_full", hs_at_full, 5);
    wait_idle();
    chk("t3_count", qx.size(), 150);
    if (qt.size() == 150) chk("t3_no_gap", qt[149] - qt[0], 149);
    for (int i = 0; i < 6; i++) check_tile("t3_pix", i * 25, i * 3, i + 1, i + 1, i % 4);

    clear_q();
    send(21, 0, 3'b010, 0);
    send(0, 25, 3'b010, 0);
    repeat (40) @(negedge clock_50);
    chk("t4_plots", qx.size(), 0);
    chk("t4_drop2", drop_count, 2);
    chk("t4_busy", busy, 0);
    for (int i = 0; i < 298; i++) send(5'(21 + i % 11), 0, 3'b011, 0);
    @(negedge clock_50);
    chk("t4_drop_sat", drop_count, 255);
    chk("t4_plots_sat", qx.size(), 0);

    clear_q();
    send(1, 1, 3'b100, 0);
    send(2, 2, 3'b101, 0);
    send(3, 3, 3'b110, 0);
    repeat (8) @(negedge clock_50);
    chk("t5_pre_plot", vga_plot, 1);
    resetn = 1'b0;
    #1;
    chk("t5_plot_now", vga_plot, 0);
    chk("t5_busy_now", busy, 0);
    chk("t5_ready_low", tile_ready, 0);
    chk("t5_drop_clr", drop_count, 0);
    repeat (2) @(negedge clock_50);
    clear_q();
    resetn = 1'b1;
    #1;
    chk("t5_ready_rel", tile_ready, 1);
    repeat (80) @(negedge clock_50);
    chk("t5_no_plots", qx.size(), 0);
    chk("t5_busy_after", busy, 0);

    clear_q();
    send(3, 4, 3'b111, 2);
    wait_idle();
    chk("t6_count", qx.size(), 25);
    colored = 0; xmin = 255; xmax = 0; ymin = 255; ymax = 0;
    foreach (qc[i]) if (qc[i] == 3'b111) begin
      colored++;
      if (qx[i] < xmin) xmin = qx[i];
      if (qx[i] > xmax) xmax = qx[i];
      if (qy[i] < ymin) ymin = qy[i];
      if (qy[i] > ymax) ymax = qy[i];
    end
    chk("t6_colored", colored, 9);
    chk("t6_xrange", {8'(xmin), 8'(xmax)}, {8'd43, 8'd45});
    chk("t6_yrange", {8'(ymin), 8'(ymax)}, {8'd28, 8'd30});
    check_tile("t6_pix", 0, 3, 4, 7, 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
